// File: rtl/fir_pkg.sv
// Shared types, default sizes and arithmetic helpers for the multi-channel FIR.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_SAT,
        ST_DONE
    } fir_state_t;

    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_COEF_W    = 16;
    localparam int unsigned DEF_COEF_FRAC = 14;
    localparam int unsigned DEF_NUM_TAPS  = 8;
    localparam int unsigned DEF_NUM_CH    = 2;

    // Accumulator wide enough that NUM_TAPS full-scale products never overflow.
    function automatic int unsigned acc_w(input int unsigned data_w,
                                          input int unsigned coef_w,
                                          input int unsigned num_taps);
        return data_w + coef_w + $clog2(num_taps);
    endfunction

    // Half an LSB of the output, added before the arithmetic shift (round-half-up).
    function automatic longint round_const(input int unsigned frac);
        return longint'(1) <<< (frac - 1);
    endfunction

    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fir_filter_mc_if.sv
// Audio frame handshake and coefficient-load bus of the multi-channel FIR.
interface fir_filter_mc_if
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned COEF_W   = DEF_COEF_W,
    parameter int unsigned NUM_TAPS = DEF_NUM_TAPS,
    parameter int unsigned NUM_CH   = DEF_NUM_CH
);
    localparam int unsigned ADDR_W = $clog2(NUM_TAPS);

    logic [NUM_CH*DATA_W-1:0] AUD_IN;
    logic                     IN_VALID;
    logic                     IN_READY;
    logic [NUM_CH*DATA_W-1:0] AUD_OUT;
    logic                     OUT_VALID;
    logic                     COEF_WE;
    logic [ADDR_W-1:0]        COEF_ADDR;
    logic signed [COEF_W-1:0] COEF_DATA;
    logic                     COEF_COMMIT;
    logic                     COMMIT_PEND;
    logic                     OVERRUN;

    modport slave (
        input  AUD_IN, IN_VALID, COEF_WE, COEF_ADDR, COEF_DATA, COEF_COMMIT,
        output IN_READY, AUD_OUT, OUT_VALID, COMMIT_PEND, OVERRUN
    );

    modport master (
        output AUD_IN, IN_VALID, COEF_WE, COEF_ADDR, COEF_DATA, COEF_COMMIT,
        input  IN_READY, AUD_OUT, OUT_VALID, COMMIT_PEND, OVERRUN
    );

endinterface

// File: rtl/fir_mac_sat.sv
// Signed multiply-accumulate with round-half-up and saturation of the running sum.
module fir_mac_sat
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned COEF_W    = DEF_COEF_W,
    parameter int unsigned COEF_FRAC = DEF_COEF_FRAC,
    parameter int unsigned NUM_TAPS  = DEF_NUM_TAPS
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic                     i_accum,
    input  logic                     i_final,
    input  logic signed [COEF_W-1:0] i_coef,
    input  logic signed [DATA_W-1:0] i_sample,
    output logic signed [DATA_W-1:0] o_result
);
    localparam int unsigned ACC_W  = acc_w(DATA_W, COEF_W, NUM_TAPS);
    localparam int unsigned PROD_W = DATA_W + COEF_W;

    localparam logic signed [ACC_W-1:0] L_RND = ACC_W'(round_const(COEF_FRAC));
    localparam logic signed [ACC_W-1:0] L_MAX = ACC_W'(sat_max(DATA_W));
    localparam logic signed [ACC_W-1:0] L_MIN = ACC_W'(sat_min(DATA_W));

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_rnd;
    logic signed [ACC_W-1:0]  w_shift;

    assign w_prod     = PROD_W'(i_coef) * PROD_W'(i_sample);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_rnd      = r_acc + L_RND;
    assign w_shift    = w_rnd >>> COEF_FRAC;

    // Clamp the rounded sum to the output sample range.
    always_comb begin
        o_result = w_shift[DATA_W-1:0];
        if (w_shift > L_MAX) begin
            o_result = DATA_W'(L_MAX);
        end else if (w_shift < L_MIN) begin
            o_result = DATA_W'(L_MIN);
        end
    end

    // Running sum: cleared at frame start and after each channel is finalised.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clear || i_final) begin
            r_acc <= '0;
        end else if (i_accum) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

endmodule

// File: rtl/fir_filter_mc.sv
// Multi-channel FIR low-pass: delay lines, double-buffered coefficients, MAC sequencer.
module fir_filter_mc
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned COEF_W    = DEF_COEF_W,
    parameter int unsigned COEF_FRAC = DEF_COEF_FRAC,
    parameter int unsigned NUM_TAPS  = DEF_NUM_TAPS,
    parameter int unsigned NUM_CH    = DEF_NUM_CH
) (
    input logic            CLK,
    input logic            RST,
    fir_filter_mc_if.slave bus
);
    localparam int unsigned TAP_W = $clog2(NUM_TAPS);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic signed [COEF_W-1:0] L_UNITY = COEF_W'(longint'(1) <<< COEF_FRAC);

    fir_state_t               r_state;
    logic [TAP_W-1:0]         r_tap;
    logic [CH_W-1:0]          r_ch;
    logic signed [DATA_W-1:0] r_dl [NUM_CH][NUM_TAPS];
    logic signed [COEF_W-1:0] r_coef_act [NUM_TAPS];
    logic signed [COEF_W-1:0] r_coef_sh [NUM_TAPS];
    logic signed [COEF_W-1:0] w_coef_sh_next [NUM_TAPS];
    logic signed [DATA_W-1:0] r_out_sh [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] r_aud_out;
    logic                     r_out_valid;
    logic                     r_in_ready;
    logic                     r_commit_pend;
    logic                     r_overrun;

    logic                     w_accept;
    logic                     w_commit_req;
    logic                     w_mac_clear;
    logic                     w_mac_accum;
    logic                     w_mac_final;
    logic signed [COEF_W-1:0] w_coef;
    logic signed [DATA_W-1:0] w_sample;
    logic signed [DATA_W-1:0] w_result;

    assign w_accept     = (r_state == ST_IDLE) && bus.IN_VALID;
    assign w_commit_req = r_commit_pend || bus.COEF_COMMIT;
    assign w_mac_clear  = w_accept;
    assign w_mac_accum  = (r_state == ST_MAC);
    assign w_mac_final  = (r_state == ST_SAT);
    assign w_coef       = r_coef_act[r_tap];
    assign w_sample     = r_dl[r_ch][r_tap];

    assign bus.IN_READY    = r_in_ready;
    assign bus.AUD_OUT     = r_aud_out;
    assign bus.OUT_VALID   = r_out_valid;
    assign bus.COMMIT_PEND = r_commit_pend;
    assign bus.OVERRUN     = r_overrun;

    // Shadow bank with this cycle's write merged in, so a same-cycle commit copies it.
    always_comb begin
        w_coef_sh_next = r_coef_sh;
        if (bus.COEF_WE && (int'(bus.COEF_ADDR) < int'(NUM_TAPS))) begin
            w_coef_sh_next[bus.COEF_ADDR] = bus.COEF_DATA;
        end
    end

    fir_mac_sat #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC),
        .NUM_TAPS  (NUM_TAPS)
    ) u_mac (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_clear  (w_mac_clear),
        .i_accum  (w_mac_accum),
        .i_final  (w_mac_final),
        .i_coef   (w_coef),
        .i_sample (w_sample),
        .o_result (w_result)
    );

    // Frame sequencer with delay lines, coefficient banks and registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= ST_IDLE;
            r_tap         <= '0;
            r_ch          <= '0;
            r_aud_out     <= '0;
            r_out_valid   <= 1'b0;
            r_in_ready    <= 1'b1;
            r_commit_pend <= 1'b0;
            r_overrun     <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                r_out_sh[c] <= '0;
                for (int unsigned t = 0; t < NUM_TAPS; t++) begin
                    r_dl[c][t] <= '0;
                end
            end
            for (int unsigned t = 0; t < NUM_TAPS; t++) begin
                r_coef_act[t] <= (t == 0) ? L_UNITY : '0;
                r_coef_sh[t]  <= (t == 0) ? L_UNITY : '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_coef_sh   <= w_coef_sh_next;

            if (bus.COEF_COMMIT) begin
                r_commit_pend <= 1'b1;
            end
            if (bus.IN_VALID && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    // Copy happens before any frame starts, so an accepted frame sees it.
                    if (w_commit_req) begin
                        r_coef_act    <= w_coef_sh_next;
                        r_commit_pend <= 1'b0;
                    end
                    if (bus.IN_VALID) begin
                        for (int unsigned c = 0; c < NUM_CH; c++) begin
                            r_dl[c][0] <= bus.AUD_IN[c*DATA_W +: DATA_W];
                            for (int unsigned t = 1; t < NUM_TAPS; t++) begin
                                r_dl[c][t] <= r_dl[c][t-1];
                            end
                        end
                        r_ch       <= '0;
                        r_tap      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (r_tap == TAP_W'(NUM_TAPS - 1)) begin
                        r_state <= ST_SAT;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                ST_SAT: begin
                    r_out_sh[r_ch] <= w_result;
                    if (r_ch == CH_W'(NUM_CH - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_tap   <= '0;
                        r_state <= ST_MAC;
                    end
                end
                ST_DONE: begin
                    for (int unsigned c = 0; c < NUM_CH; c++) begin
                        r_aud_out[c*DATA_W +: DATA_W] <= r_out_sh[c];
                    end
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
